// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding request to instruction memory, delayed-branch
// redirect, exception flush with response cancel, and misaligned-fetch (AdEL) reporting.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid,
  output logic        adel
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] redir_addr_q, redir_addr_d;
  logic        redir_pend_q, redir_pend_d;
  logic        cancel_q, cancel_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        adel_q, adel_d;

  logic        misaligned;
  logic        out_busy;
  logic        accept;
  logic        branch_take;
  logic [31:0] next_pc;

  assign misaligned  = fetch_pc_q[1:0] != 2'b00;
  // A live instruction that ID has not yet taken blocks any new request.
  assign out_busy    = valid_q & stall;
  assign accept      = inst_req & inst_addr_ok;
  assign branch_take = branch & valid_q & ~stall & ~adel_q & ~flush;
  assign next_pc     = redir_pend_q ? redir_addr_q : fetch_pc_q + 32'd4;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: begin
        if (flush) begin
          if (accept) state_d = StWait;
        end else if (misaligned) begin
          if (!out_busy) state_d = StHold;
        end else if (accept) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          state_d = (flush || cancel_q || !stall) ? StReq : StHold;
        end
      end
      StHold: begin
        // An AdEL presentation is only left through a flush.
        if (flush || (!adel_q && !stall)) state_d = StReq;
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q   <= RESET_PC;
      req_pc_q     <= 32'h0;
      redir_addr_q <= 32'h0;
      redir_pend_q <= 1'b0;
      cancel_q     <= 1'b0;
      pc_q         <= 32'h0;
      inst_q       <= 32'h0;
      valid_q      <= 1'b0;
      adel_q       <= 1'b0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      req_pc_q     <= req_pc_d;
      redir_addr_q <= redir_addr_d;
      redir_pend_q <= redir_pend_d;
      cancel_q     <= cancel_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      adel_q       <= adel_d;
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    req_pc_d     = req_pc_q;
    redir_addr_d = redir_addr_q;
    redir_pend_d = redir_pend_q;
    cancel_d     = cancel_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    adel_d       = adel_q;

    if (valid_q && !stall && !adel_q) valid_d = 1'b0;
    if (accept) req_pc_d = fetch_pc_q;

    if (flush) begin
      fetch_pc_d   = flush_addr;
      redir_pend_d = 1'b0;
      valid_d      = 1'b0;
      adel_d       = 1'b0;
      // A request already in flight must have its response swallowed.
      cancel_d     = ((state_q == StReq) && accept) || ((state_q == StWait) && !inst_data_ok);
    end else begin
      unique case (state_q)
        StReq: begin
          if (misaligned) begin
            if (!out_busy) begin
              pc_d    = fetch_pc_q;
              inst_d  = 32'h0;
              valid_d = 1'b1;
              adel_d  = 1'b1;
            end
          end else if (accept) begin
            fetch_pc_d   = next_pc;
            redir_pend_d = 1'b0;
          end
        end
        StWait: begin
          if (inst_data_ok) begin
            if (cancel_q) begin
              cancel_d = 1'b0;
            end else begin
              pc_d    = req_pc_q;
              inst_d  = inst_rdata;
              valid_d = 1'b1;
              adel_d  = 1'b0;
            end
          end
        end
        default: ;
      endcase

      // Delay slot already accepted: redirect now; otherwise park the target.
      if (branch_take) begin
        if ((state_q == StWait) || accept) begin
          fetch_pc_d   = branch_addr;
          redir_pend_d = 1'b0;
        end else begin
          redir_pend_d = 1'b1;
          redir_addr_d = branch_addr;
        end
      end
    end
  end

  always_comb begin
    inst_req  = resetn && (state_q == StReq) && !misaligned && !out_busy;
    inst_addr = fetch_pc_q;
    pc        = pc_q;
    inst      = inst_q;
    valid     = valid_q;
    adel      = adel_q;
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed vector table, hand-written corner sequences, then randomized
// memory latency/stall/branch/flush against a program-order delivery model.
module tb_fetch;

  localparam logic [31:0] RST = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, branch = 1'b0;
  logic [31:0] flush_addr = 32'h0, branch_addr = 32'h0, inst_rdata = 32'h0;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic        inst_req, valid, adel;
  logic [31:0] inst_addr, pc, inst;

  int checks = 0;
  int failures = 0;

  fetch #(.RESET_PC(RST)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .stall        (stall),
    .flush        (flush),
    .flush_addr   (flush_addr),
    .branch       (branch),
    .branch_addr  (branch_addr),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pc           (pc),
    .inst         (inst),
    .valid        (valid),
    .adel         (adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic [31:0] fa, input logic b,
                       input logic [31:0] ba, input logic ao, input logic dk,
                       input logic [31:0] rd);
    @(negedge clk);
    stall = s; flush = f; flush_addr = fa; branch = b; branch_addr = ba;
    inst_addr_ok = ao; inst_data_ok = dk; inst_rdata = rd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Random-phase state
  logic [31:0] exp_next, br_tgt, mem_addr, prev_addr;
  logic        br_pend, cur_slot, mem_busy;
  logic        prev_valid, prev_stall, prev_req, prev_aok, prev_flush;
  logic        s, f, b, dk, ao;
  logic [31:0] fa, ba, rd;
  int          mem_cnt, delivered;

  initial begin
    //            stall aok dok rdata         req addr          vld pc            inst
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, RST,          1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, RST,          1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'h24080001, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hBFC00004, 1'b1, RST,          32'h24080001};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0, 32'h0,        1'b0, RST,          32'h24080001};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hBFC00008, 1'b1, 32'hBFC00004, 32'h11111111};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h22222222, 1'b0, 32'h0,        1'b0, 32'hBFC00004, 32'h11111111};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00008, 32'h22222222};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00008, 32'h22222222};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00008, 32'h22222222};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hBFC00008, 32'h22222222};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hBFC0000C, 1'b0, 32'hBFC00008, 32'h22222222};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_req", inst_req, 1'b0);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_adel", adel, 1'b0);
    chk32("rst_pc", pc, 32'h0);
    chk32("rst_inst", inst, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vector table: first fetch, zero-wait stream, 3-cycle stall
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].stall, 1'b0, 32'h0, 1'b0, 32'h0, tbl[i].aok, tbl[i].dok, tbl[i].rdata);
      chk1($sformatf("tbl%0d_req", i), inst_req, tbl[i].e_req);
      if (tbl[i].e_req) chk32($sformatf("tbl%0d_addr", i), inst_addr, tbl[i].e_addr);
      chk1($sformatf("tbl%0d_valid", i), valid, tbl[i].e_valid);
      chk32($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk32($sformatf("tbl%0d_inst", i), inst, tbl[i].e_inst);
      chk1($sformatf("tbl%0d_adel", i), adel, 1'b0);
    end

    // Branch with delay slot, target parked until pc+4 is accepted
    drive(1'b0, 1'b1, 32'hBFC00010, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk32("br_first_addr", inst_addr, 32'hBFC00010);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA0010);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h80001000, 1'b0, 1'b0, 32'h0);
    chk1("br_valid", valid, 1'b1);
    chk32("br_pc", pc, 32'hBFC00010);
    chk32("br_slot_addr", inst_addr, 32'hBFC00014);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk32("br_slot_addr_hold", inst_addr, 32'hBFC00014);
    chk1("br_consumed", valid, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBBBB0014);
    idle();
    chk32("br_slot_pc", pc, 32'hBFC00014);
    chk32("br_slot_inst", inst, 32'hBBBB0014);
    chk1("br_tgt_req", inst_req, 1'b1);
    chk32("br_tgt_addr", inst_addr, 32'h80001000);

    // Flush during WAIT: late response dropped
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 32'hBFC00380, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    chk1("fl_noreq_wait", inst_req, 1'b0);
    idle();
    chk1("fl_valid", valid, 1'b0);
    chk32("fl_pc_kept", pc, 32'hBFC00014);
    chk32("fl_addr", inst_addr, 32'hBFC00380);

    // Misaligned branch target after delay slot (branch in the accept cycle)
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC0000380);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h80001002, 1'b1, 1'b0, 32'h0);
    chk32("ad_br_pc", pc, 32'hBFC00380);
    chk32("ad_slot_addr", inst_addr, 32'hBFC00384);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hD0000384);
    idle();
    chk32("ad_slot_pc", pc, 32'hBFC00384);
    chk1("ad_slot_adel", adel, 1'b0);
    chk1("ad_noreq", inst_req, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk1($sformatf("ad_adel%0d", i), adel, 1'b1);
      chk1($sformatf("ad_valid%0d", i), valid, 1'b1);
      chk32($sformatf("ad_pc%0d", i), pc, 32'h80001002);
      chk32($sformatf("ad_inst%0d", i), inst, 32'h0);
      chk1($sformatf("ad_req%0d", i), inst_req, 1'b0);
    end
    drive(1'b0, 1'b1, 32'hBFC00400, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    idle();
    chk1("ad_fl_adel", adel, 1'b0);
    chk1("ad_fl_valid", valid, 1'b0);
    chk32("ad_fl_addr", inst_addr, 32'hBFC00400);
    chk1("ad_fl_req", inst_req, 1'b1);

    // PC wrap
    drive(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk32("wr_addr", inst_addr, 32'hFFFFFFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678);
    idle();
    chk32("wr_pc", pc, 32'hFFFFFFFC);
    chk32("wr_next_addr", inst_addr, 32'h0);

    // Reset while a request is outstanding; stale response ignored
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    inst_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk1("mr_req", inst_req, 1'b0);
    chk1("mr_valid", valid, 1'b0);
    chk32("mr_pc", pc, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata = 32'h99999999;
    #1;
    chk1("mr_first_req", inst_req, 1'b1);
    chk32("mr_first_addr", inst_addr, RST);
    idle();
    chk1("mr_stale_valid", valid, 1'b0);
    chk32("mr_stale_inst", inst, 32'h0);

    // Randomized phase
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_next = RST; br_pend = 1'b0; cur_slot = 1'b0; mem_busy = 1'b0; mem_cnt = 0;
    br_tgt = 32'h0; mem_addr = 32'h0; delivered = 0;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_req = 1'b0; prev_aok = 1'b0;
    prev_flush = 1'b0; prev_addr = 32'h0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      #1;
      if (valid && !(prev_valid && prev_stall)) begin
        chk32("rnd_pc", pc, exp_next);
        chk32("rnd_inst", inst, mem_word(exp_next));
        chk1("rnd_adel", adel, 1'b0);
        cur_slot = br_pend;
        if (br_pend) begin
          exp_next = br_tgt;
          br_pend = 1'b0;
        end else begin
          exp_next = exp_next + 32'd4;
        end
        delivered++;
      end
      s  = ($urandom % 4) == 0;
      f  = ($urandom % 60) == 0;
      fa = (($urandom % 8) == 0) ? 32'hFFFFFFF8 : ($urandom & 32'hFFFFFFFC);
      b  = (($urandom % 3) == 0) && !(valid && cur_slot);
      ba = $urandom & 32'hFFFFFFFC;
      dk = 1'b0;
      rd = $urandom;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          dk = 1'b1;
          rd = mem_word(mem_addr);
          mem_busy = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      stall = s; flush = f; flush_addr = fa; branch = b; branch_addr = ba;
      inst_data_ok = dk; inst_rdata = rd; inst_addr_ok = 1'b0;
      #1;
      if (prev_req && !prev_aok && !prev_flush) begin
        chk1("rnd_req_hold", inst_req, 1'b1);
        chk32("rnd_addr_hold", inst_addr, prev_addr);
      end
      if (inst_req) chk1("rnd_one_outstanding", mem_busy, 1'b0);
      ao = inst_req && (($urandom % 3) != 0);
      inst_addr_ok = ao;
      if (ao) begin
        mem_busy = 1'b1;
        mem_addr = inst_addr;
        mem_cnt = $urandom % 3;
      end
      if (f) begin
        exp_next = fa;
        br_pend = 1'b0;
      end else if (b && valid && !s) begin
        br_pend = 1'b1;
        br_tgt = ba;
      end
      prev_valid = valid; prev_stall = s; prev_req = inst_req; prev_aok = ao;
      prev_flush = f; prev_addr = inst_addr;
    end
    chk1("rnd_progress", delivered > 200, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
